// File: rtl/out_fm_tile_scheduler_pkg.sv
// Shared types and constants for the output feature-map tile scheduler.
package out_fm_tile_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitDone = 2'd2,
    StNext     = 2'd3
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned num_tiles(input int unsigned n, input int unsigned r,
                                            input int unsigned c, input int unsigned tn,
                                            input int unsigned tr, input int unsigned tc);
    return ceil_div(n, tn) * ceil_div(r, tr) * ceil_div(c, tc);
  endfunction

endpackage

// File: rtl/out_fm_tile_scheduler_if.sv
// Control, mover handshake and tile-origin signals of the tile scheduler.
interface out_fm_tile_scheduler_if #(
  parameter int unsigned AW = 32
);
  logic          start;
  logic          done;
  logic          busy;
  logic          hold;
  logic          mover_start;
  logic          mover_done;
  logic [AW-1:0] tile_base_n;
  logic [AW-1:0] tile_base_row;
  logic [AW-1:0] tile_base_col;
  logic [AW-1:0] tile_idx;

  modport master (
    output start, hold, mover_done,
    input  done, busy, mover_start, tile_base_n, tile_base_row, tile_base_col, tile_idx
  );

  modport slave (
    input  start, hold, mover_done,
    output done, busy, mover_start, tile_base_n, tile_base_row, tile_base_col, tile_idx
  );
endinterface

// File: rtl/out_fm_tile_scheduler_tile_base_stepper.sv
// Three-level wrapping tile-origin counter: column innermost, then row, then channel.
module out_fm_tile_scheduler_tile_base_stepper #(
  parameter int unsigned AW = 32,
  parameter int unsigned N  = 32,
  parameter int unsigned R  = 64,
  parameter int unsigned C  = 32,
  parameter int unsigned Tn = 8,
  parameter int unsigned Tr = 16,
  parameter int unsigned Tc = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [AW-1:0] n_o,
  output logic [AW-1:0] row_o,
  output logic [AW-1:0] col_o,
  output logic          last_o
);
  localparam logic [AW-1:0] NW  = AW'(N);
  localparam logic [AW-1:0] RW  = AW'(R);
  localparam logic [AW-1:0] CW  = AW'(C);
  localparam logic [AW-1:0] TnW = AW'(Tn);
  localparam logic [AW-1:0] TrW = AW'(Tr);
  localparam logic [AW-1:0] TcW = AW'(Tc);

  logic [AW-1:0] n_q, n_d, row_q, row_d, col_q, col_d;
  logic          col_wrap, row_wrap, n_wrap;

  // Compare the stepped value before wrapping so partial edge tiles are still issued.
  assign col_wrap = (col_q + TcW) >= CW;
  assign row_wrap = (row_q + TrW) >= RW;
  assign n_wrap   = (n_q + TnW) >= NW;

  always_comb begin
    n_d   = n_q;
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      n_d   = '0;
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (!col_wrap) begin
        col_d = col_q + TcW;
      end else begin
        col_d = '0;
        if (!row_wrap) begin
          row_d = row_q + TrW;
        end else begin
          row_d = '0;
          n_d   = n_q + TnW;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q   <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      n_q   <= n_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign n_o    = n_q;
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = col_wrap & row_wrap & n_wrap;

endmodule

// File: rtl/out_fm_tile_scheduler.sv
// Streams an output feature map as a sequence of tile transfers, one mover handshake per tile.
module out_fm_tile_scheduler
  import out_fm_tile_scheduler_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned N  = 32,
  parameter int unsigned R  = 64,
  parameter int unsigned C  = 32,
  parameter int unsigned Tn = 8,
  parameter int unsigned Tr = 16,
  parameter int unsigned Tc = 8
) (
  input logic                    clk,
  input logic                    rst,
  out_fm_tile_scheduler_if.slave bus
);
  localparam int unsigned NumTiles = num_tiles(N, R, C, Tn, Tr, Tc);

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mstart_q, mstart_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          clear, advance, last;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mstart_d = 1'b0;
    idx_d    = idx_q;
    clear    = 1'b0;
    advance  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StIssue;
          busy_d  = 1'b1;
          idx_d   = '0;
          clear   = 1'b1;
        end
      end
      StIssue: begin
        if (!bus.hold) begin
          mstart_d = 1'b1;
          state_d  = StWaitDone;
        end
      end
      StWaitDone: begin
        // A mover_done overlapping our own mover_start pulse belongs to no transfer.
        if (bus.mover_done && !mstart_q) state_d = StNext;
      end
      StNext: begin
        if (last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          advance = 1'b1;
          idx_d   = idx_q + AW'(1);
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mstart_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mstart_q <= mstart_d;
      idx_q    <= idx_d;
    end
  end

  out_fm_tile_scheduler_tile_base_stepper #(
    .AW(AW), .N(N), .R(R), .C(C), .Tn(Tn), .Tr(Tr), .Tc(Tc)
  ) u_stepper (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .advance_i(advance),
    .n_o      (bus.tile_base_n),
    .row_o    (bus.tile_base_row),
    .col_o    (bus.tile_base_col),
    .last_o   (last)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mover_start = mstart_q;
  assign bus.tile_idx    = idx_q;

  last_tile_idx_a: assert property (@(posedge clk) disable iff (rst)
    (state_q == StNext && last) |-> (idx_q == AW'(NumTiles - 1)));

endmodule

// File: tb/tb_out_fm_tile_scheduler.sv
// Directed bench: a small geometry against a tile table and the default geometry against a model.
module tb_out_fm_tile_scheduler;

  typedef struct {
    int unsigned idx;
    int unsigned n;
    int unsigned row;
    int unsigned col;
  } tile_vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned ms_s = 0, done_s = 0, ms_d = 0, done_d = 0;
  logic        rsp_en_s = 1'b0, rsp_en_d = 1'b0;
  logic        rsp_s = 1'b0, rsp_d = 1'b0, md_s = 1'b0;
  tile_vec_t   vec [4];

  always #5 clk = ~clk;

  out_fm_tile_scheduler_if #(.AW(32)) s_if ();
  out_fm_tile_scheduler_if #(.AW(32)) d_if ();

  assign s_if.mover_done = rsp_s | md_s;
  assign d_if.mover_done = rsp_d;

  out_fm_tile_scheduler #(
    .AW(32), .N(4), .R(4), .C(6), .Tn(2), .Tr(4), .Tc(4)
  ) u_small (
    .clk(clk),
    .rst(rst),
    .bus(s_if)
  );

  out_fm_tile_scheduler #(
    .AW(32)
  ) u_dflt (
    .clk(clk),
    .rst(rst),
    .bus(d_if)
  );

  // Mover models: small one answers 5 cycles after mover_start, default one the next cycle.
  always begin
    @(negedge clk);
    if (s_if.mover_start && rsp_en_s) begin
      repeat (4) @(negedge clk);
      if (rsp_en_s) begin
        rsp_s = 1'b1;
        @(negedge clk);
        rsp_s = 1'b0;
      end
    end
  end

  always begin
    @(negedge clk);
    if (d_if.mover_start && rsp_en_d) begin
      @(negedge clk);
      if (rsp_en_d) begin
        rsp_d = 1'b1;
        @(negedge clk);
        rsp_d = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_s();
    @(negedge clk);
    if (s_if.mover_start) begin
      if (ms_s < 4) begin
        chk("s_tile_idx", s_if.tile_idx, vec[ms_s].idx);
        chk("s_base_n", s_if.tile_base_n, vec[ms_s].n);
        chk("s_base_row", s_if.tile_base_row, vec[ms_s].row);
        chk("s_base_col", s_if.tile_base_col, vec[ms_s].col);
      end else begin
        chk("s_extra_pulse", ms_s, 3);
      end
      ms_s++;
    end
    if (s_if.done) done_s++;
  endtask

  task automatic step_d();
    @(negedge clk);
    if (d_if.mover_start) begin
      chk("d_tile_idx", d_if.tile_idx, ms_d);
      chk("d_base_n", d_if.tile_base_n, (ms_d / 16) * 8);
      chk("d_base_row", d_if.tile_base_row, ((ms_d / 4) % 4) * 16);
      chk("d_base_col", d_if.tile_base_col, (ms_d % 4) * 8);
      ms_d++;
    end
    if (d_if.done) done_d++;
  endtask

  initial begin
    vec[0] = '{idx: 0, n: 0, row: 0, col: 0};
    vec[1] = '{idx: 1, n: 0, row: 0, col: 4};
    vec[2] = '{idx: 2, n: 2, row: 0, col: 0};
    vec[3] = '{idx: 3, n: 2, row: 0, col: 4};
    s_if.start = 1'b0;
    s_if.hold  = 1'b0;
    d_if.start = 1'b0;
    d_if.hold  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_s_busy", 32'(s_if.busy), 0);
    chk("rst_s_done", 32'(s_if.done), 0);
    chk("rst_s_mstart", 32'(s_if.mover_start), 0);
    chk("rst_s_idx", s_if.tile_idx, 0);
    chk("rst_d_busy", 32'(d_if.busy), 0);
    chk("rst_d_base_col", d_if.tile_base_col, 0);
    rst = 1'b0;

    // Small geometry, table of four tiles, mover answers after 5 cycles.
    rsp_en_s   = 1'b1;
    @(negedge clk);
    s_if.start = 1'b1;
    step_s();
    s_if.start = 1'b0;
    for (int i = 0; i < 200 && done_s == 0; i++) step_s();
    repeat (3) step_s();
    chk("s_tiles", ms_s, 4);
    chk("s_done_cnt", done_s, 1);
    chk("s_busy_after", 32'(s_if.busy), 0);
    chk("s_last_n_held", s_if.tile_base_n, 2);
    chk("s_last_col_held", s_if.tile_base_col, 4);

    // Small geometry by hand: latency, masked/spurious mover_done, start while busy.
    rsp_en_s   = 1'b0;
    ms_s       = 0;
    done_s     = 0;
    s_if.start = 1'b1;
    step_s();
    s_if.start = 1'b0;
    chk("lat_busy_k", 32'(s_if.busy), 1);
    chk("lat_mstart_k", 32'(s_if.mover_start), 0);
    step_s();
    chk("lat_mstart_k1", 32'(s_if.mover_start), 1);
    md_s = 1'b1;
    step_s();
    md_s       = 1'b0;
    s_if.start = 1'b1;
    step_s();
    s_if.start = 1'b0;
    repeat (2) step_s();
    chk("coincident_done_ignored_idx", s_if.tile_idx, 0);
    chk("coincident_done_ignored_pulses", ms_s, 1);
    md_s = 1'b1;
    step_s();
    md_s = 1'b0;
    chk("lat_mstart_m", 32'(s_if.mover_start), 0);
    chk("lat_busy_m", 32'(s_if.busy), 1);
    step_s();
    chk("lat_mstart_m1", 32'(s_if.mover_start), 0);
    chk("lat_idx_m1", s_if.tile_idx, 1);
    step_s();
    chk("lat_mstart_m2", 32'(s_if.mover_start), 1);
    repeat (2) step_s();
    md_s = 1'b1;
    step_s();
    md_s      = 1'b0;
    s_if.hold = 1'b1;
    step_s();
    md_s = 1'b1;
    step_s();
    md_s      = 1'b0;
    s_if.hold = 1'b0;
    step_s();
    chk("spur_issue_mstart", 32'(s_if.mover_start), 1);
    repeat (3) step_s();
    chk("spur_issue_idx", s_if.tile_idx, 2);
    chk("spur_issue_pulses", ms_s, 3);
    md_s = 1'b1;
    step_s();
    md_s     = 1'b0;
    rsp_en_s = 1'b1;
    for (int i = 0; i < 60 && done_s == 0; i++) step_s();
    chk("hand_tiles", ms_s, 4);
    chk("hand_done_cnt", done_s, 1);
    chk("hand_busy_after", 32'(s_if.busy), 0);

    // Default geometry, immediate mover_done, hold for 10 cycles in tile 3's issue.
    rsp_en_d   = 1'b1;
    d_if.start = 1'b1;
    step_d();
    d_if.start = 1'b0;
    for (int i = 0; i < 40 && ms_d < 3; i++) step_d();
    chk("d_reached_tile2", ms_d, 3);
    d_if.hold = 1'b1;
    for (int i = 0; i < 40 && d_if.tile_idx != 3; i++) step_d();
    chk("hold_in_tile3", d_if.tile_idx, 3);
    for (int i = 0; i < 9; i++) begin
      step_d();
      chk("hold_no_mstart", 32'(d_if.mover_start), 0);
    end
    chk("hold_base_col", d_if.tile_base_col, 24);
    chk("hold_base_row", d_if.tile_base_row, 0);
    d_if.hold = 1'b0;
    step_d();
    chk("hold_release_mstart", 32'(d_if.mover_start), 1);
    for (int i = 0; i < 2000 && done_d == 0; i++) step_d();
    repeat (5) step_d();
    chk("d_tiles", ms_d, 64);
    chk("d_done_cnt", done_d, 1);
    chk("d_busy_after", 32'(d_if.busy), 0);
    chk("d_last_n", d_if.tile_base_n, 24);
    chk("d_last_row", d_if.tile_base_row, 48);
    chk("d_last_col", d_if.tile_base_col, 24);

    // Reset in WAIT_DONE of tile 5, then restart from tile 0.
    ms_d       = 0;
    done_d     = 0;
    d_if.start = 1'b1;
    step_d();
    d_if.start = 1'b0;
    for (int i = 0; i < 100 && d_if.tile_idx != 5; i++) step_d();
    rsp_en_d = 1'b0;
    repeat (4) step_d();
    chk("pre_rst_pulses", ms_d, 6);
    chk("pre_rst_busy", 32'(d_if.busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(d_if.busy), 0);
    chk("rst_mstart", 32'(d_if.mover_start), 0);
    chk("rst_idx", d_if.tile_idx, 0);
    chk("rst_base_n", d_if.tile_base_n, 0);
    chk("rst_base_col", d_if.tile_base_col, 0);
    step_d();
    rst = 1'b0;
    repeat (5) step_d();
    chk("rst_no_done", done_d, 0);
    ms_d       = 0;
    rsp_en_d   = 1'b1;
    d_if.start = 1'b1;
    step_d();
    d_if.start = 1'b0;
    for (int i = 0; i < 10 && ms_d == 0; i++) step_d();
    chk("restart_first_tile", ms_d, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_fm_tile_scheduler.md
OUT_FM_TILE_SCHEDULER -- requirements
Module: out_fm_tile_scheduler

Interface
REQ-001 SHALL have parameter AW, default 32, address/counter width.
REQ-002 SHALL have parameters N=32, R=64, C=32: output feature-map channels, rows and columns.
REQ-003 SHALL have parameters Tn=8, Tr=16, Tc=8: tile size in channels, rows and columns.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to stream the whole feature map.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the last tile completes.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port hold  input  1  back-pressure; blocks issue of the next tile.
REQ-010 SHALL have port mover_start  output  1  one-cycle pulse launching one tile transfer.
REQ-011 SHALL have port mover_done  input  1  one-cycle pulse: tile transfer finished.
REQ-012 SHALL have ports tile_base_n, tile_base_row, tile_base_col  output  AW each  origin of the current tile.
REQ-013 SHALL have port tile_idx  output  AW  zero-based sequence number of the current tile.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_DONE, NEXT; all outputs registered.
REQ-015 IDLE: start=1 at an edge -> ISSUE, busy=1, bases and tile_idx cleared to 0.
REQ-016 ISSUE: hold=0 at an edge -> mover_start=1 for exactly one cycle, -> WAIT_DONE; hold=1 -> stay, no pulse.
REQ-017 WAIT_DONE: mover_done=1 at an edge -> NEXT; otherwise stay.
REQ-018 NEXT, not last tile: advance bases, tile_idx+1, -> ISSUE.
REQ-019 NEXT, last tile: done=1 for one cycle, busy=0, -> IDLE; bases hold last values.
REQ-020 Tile order SHALL be column innermost, then row, then channel; col steps by Tc while col+Tc<C else wraps to 0 and row steps by Tr; row wraps likewise into n stepping by Tn.
REQ-021 Last tile SHALL be the one where col+Tc>=C, row+Tr>=R and n+Tn>=N; partial edge tiles are issued (bases only, edge clipping is the mover's job).
REQ-022 Total tiles SHALL equal ceil(N/Tn)*ceil(R/Tr)*ceil(C/Tc); 64 at defaults.
REQ-023 Latency: start at edge k -> mover_start high after edge k+1 (hold=0); mover_done at edge m -> next mover_start after edge m+2, or done after edge m+1.
REQ-024 Bases and tile_idx SHALL be stable from mover_start until the NEXT state.
REQ-025 start while busy=1 SHALL be ignored; mover_done outside WAIT_DONE SHALL be ignored.
REQ-026 mover_done coincident with mover_start's own cycle is not counted (WAIT_DONE entered only after the pulse edge).
REQ-027 start and done SHALL never coincide internally; start in the same cycle as done (state IDLE next) is accepted only on the following edge.
REQ-028 Base arithmetic SHALL be AW-bit unsigned, compares done before wrap; no overflow for N,R,C < 2^(AW-1).

Reset
REQ-029 rst=1 SHALL force IDLE immediately; busy, done, mover_start = 0; bases, tile_idx = 0.
REQ-030 rst mid-transfer SHALL abandon the sequence; no done pulse; a fresh start restarts from tile 0.

Structure
REQ-031 State encoding constants SHALL live in the shared package; tile-count derivation as a package constant function.
REQ-032 One sub-module, tile_base_stepper: 3-level wrapping step counter (col/row/n) with advance input and last output.

Verification
REQ-033 N=4,R=4,C=6,Tn=2,Tr=4,Tc=4, mover_done 5 cycles after each mover_start -> 4 tiles, bases (0,0,0),(0,0,4),(2,0,0),(2,0,4), tile_idx 0..3, one done.
REQ-034 Defaults, immediate mover_done -> exactly 64 mover_start pulses, last base (24,48,24), done once, busy low after.
REQ-035 hold=1 for 10 cycles in ISSUE of tile 3 -> no mover_start during hold, pulse one cycle after hold drops, bases unchanged.
REQ-036 start pulsed during tile 2 and spurious mover_done in ISSUE -> no restart, no tile skipped, tile count unchanged.
REQ-037 rst asserted in WAIT_DONE of tile 5 -> all outputs 0 same cycle, no done; subsequent start issues base (0,0,0), tile_idx 0.
